// File: rtl/i2s_dual_capture_ctrl.sv
// i2s_dual_capture_ctrl
// Sequences one two-microphone acoustic capture: arms both I2S receivers on a
// trigger edge, drops warm-up frames, pairs mic1/mic2 samples into the capture
// buffer, then hands the full buffer to the direction estimator.
module i2s_dual_capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SAMPLE_W   = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8,
    parameter int WARMUP     = 4,
    parameter int SKEW_MAX   = 64
) (
    input  logic                  i_sys_clk,
    input  logic                  rst_n,
    input  logic                  i_trigger,
    input  logic                  i_rx1_vld,
    input  logic [DATA_WIDTH-1:0] i_rx1_data,
    input  logic                  i_rx2_vld,
    input  logic [DATA_WIDTH-1:0] i_rx2_data,
    output logic                  o_rx_en,
    output logic                  o_wr_en,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [2*SAMPLE_W-1:0] o_wr_data,
    output logic                  o_proc_start,
    input  logic                  i_proc_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int SKEW_W = $clog2(SKEW_MAX + 1);
    localparam int WARM_W = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        PROCESS = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic                  trig_meta_reg, trig_sync_reg, trig_prev_reg;
    logic                  trig_edge;
    logic [WARM_W-1:0]     warm_cnt_reg;
    logic                  warm_done;
    logic [SKEW_W-1:0]     skew_cnt_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  wr_en_reg;
    logic [2*SAMPLE_W-1:0] wr_data_reg;
    logic                  proc_start_reg;
    logic                  err_reg;

    logic                  in_capture;
    logic                  last_write;
    logic                  cap_active;
    logic [1:0]            vld;
    logic [1:0]            pend;
    logic [1:0]            pend_set;
    logic                  pair_fire;
    logic                  overrun;
    logic                  skew_timeout;
    logic                  capture_err;
    logic [SAMPLE_W-1:0]   sample    [2];
    logic [SAMPLE_W-1:0]   pair_word [2];
    logic                  unused_low_bits;

    // Mic data is MSB-aligned: keep only the top SAMPLE_W bits of each word.
    assign sample[0] = i_rx1_data[DATA_WIDTH-1 -: SAMPLE_W];
    assign sample[1] = i_rx2_data[DATA_WIDTH-1 -: SAMPLE_W];
    assign unused_low_bits = &{1'b0, i_rx1_data[DATA_WIDTH-SAMPLE_W-1:0],
                               i_rx2_data[DATA_WIDTH-SAMPLE_W-1:0]};

    assign trig_edge  = trig_sync_reg & ~trig_prev_reg;
    assign warm_done  = (state_reg == ARM) && i_rx1_vld
                        && (warm_cnt_reg == WARM_W'(WARMUP - 1));
    assign in_capture = (state_reg == CAPTURE);
    // The final write cycle closes the capture; anything arriving then is dropped
    // so no stray write can spill into PROCESS.
    assign last_write = wr_en_reg && (addr_reg == ADDR_W'(DEPTH - 1));
    assign cap_active = in_capture && !last_write;

    assign vld      = {i_rx2_vld, i_rx1_vld} & {2{cap_active}};
    assign pend_set = pend | vld;
    assign pair_fire = &pend_set;
    // Overrun: a channel produces again while its own sample is still waiting
    // and the partner has not shown up.
    assign overrun  = |(vld & pend & ~{pend[0], pend[1]});
    assign skew_timeout = cap_active && (|pend) && !pair_fire
                          && (skew_cnt_reg == SKEW_W'(SKEW_MAX - 1));
    assign capture_err  = overrun || skew_timeout;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [SAMPLE_W-1:0] hold_reg;
            logic                pend_reg;

            // Per-mic holding register and pending flag, cleared when a pair completes.
            always_ff @(posedge i_sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    if (vld[gi]) begin
                        hold_reg <= sample[gi];
                    end
                    if (!in_capture || pair_fire) begin
                        pend_reg <= 1'b0;
                    end else begin
                        pend_reg <= pend_set[gi];
                    end
                end
            end

            assign pend[gi]      = pend_reg;
            // A sample arriving on the completing cycle bypasses the holding register.
            assign pair_word[gi] = vld[gi] ? sample[gi] : hold_reg;
        end
    endgenerate

    // Trigger synchroniser and edge-detect history.
    always_ff @(posedge i_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_meta_reg <= 1'b0;
            trig_sync_reg <= 1'b0;
            trig_prev_reg <= 1'b0;
        end else begin
            trig_meta_reg <= i_trigger;
            trig_sync_reg <= trig_meta_reg;
            trig_prev_reg <= trig_sync_reg;
        end
    end

    // State register.
    always_ff @(posedge i_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; trigger edges only matter in IDLE, done only in PROCESS.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trig_edge) state_next = ARM;
            ARM:     if (warm_done) state_next = CAPTURE;
            CAPTURE: begin
                if (capture_err) begin
                    state_next = IDLE;
                end else if (last_write) begin
                    state_next = PROCESS;
                end
            end
            PROCESS: if (i_proc_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Warm-up counter: mic1 frames seen while armed.
    always_ff @(posedge i_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_reg <= '0;
        end else if (state_reg != ARM) begin
            warm_cnt_reg <= '0;
        end else if (i_rx1_vld) begin
            warm_cnt_reg <= warm_cnt_reg + 1'b1;
        end
    end

    // Skew timer: cycles a lone sample has been waiting for its partner.
    always_ff @(posedge i_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_cnt_reg <= '0;
        end else if (!in_capture || pair_fire || !(|pend)) begin
            skew_cnt_reg <= '0;
        end else begin
            skew_cnt_reg <= skew_cnt_reg + 1'b1;
        end
    end

    // Buffer write port: one strobe the cycle after a pair completes.
    always_ff @(posedge i_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= pair_fire && !capture_err;
            if (pair_fire && !capture_err) begin
                wr_data_reg <= {pair_word[0], pair_word[1]};
            end
        end
    end

    // Write address: starts at 0 each capture, advances after every write, never wraps.
    always_ff @(posedge i_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (!in_capture) begin
            addr_reg <= '0;
        end else if (wr_en_reg && !last_write) begin
            addr_reg <= addr_reg + 1'b1;
        end
    end

    // Estimator start pulse on PROCESS entry, and the sticky error flag.
    always_ff @(posedge i_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_start_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            proc_start_reg <= (state_next == PROCESS) && (state_reg != PROCESS);
            if ((state_reg == IDLE) && trig_edge) begin
                err_reg <= 1'b0;
            end else if (in_capture && capture_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign o_rx_en      = (state_reg == ARM) || (state_reg == CAPTURE);
    assign o_busy       = (state_reg != IDLE);
    assign o_wr_en      = wr_en_reg;
    assign o_wr_addr    = addr_reg;
    assign o_wr_data    = wr_data_reg;
    assign o_proc_start = proc_start_reg;
    assign o_err        = err_reg;

endmodule

// File: tb/tb_i2s_dual_capture_ctrl.sv
// Directed testbench for i2s_dual_capture_ctrl: full captures with aligned and
// lagging mics, skew timeout, overrun, trigger/done handshake and mid-capture reset.
module tb_i2s_dual_capture_ctrl;

    logic        i_sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_trigger = 1'b0;
    logic        i_rx1_vld = 1'b0;
    logic [31:0] i_rx1_data = '0;
    logic        i_rx2_vld = 1'b0;
    logic [31:0] i_rx2_data = '0;
    logic        o_rx_en;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_proc_start;
    logic        i_proc_done = 1'b0;
    logic        o_busy;
    logic        o_err;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          start_count = 0;
    logic [7:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    i2s_dual_capture_ctrl dut (
        .i_sys_clk   (i_sys_clk),
        .rst_n       (rst_n),
        .i_trigger   (i_trigger),
        .i_rx1_vld   (i_rx1_vld),
        .i_rx1_data  (i_rx1_data),
        .i_rx2_vld   (i_rx2_vld),
        .i_rx2_data  (i_rx2_data),
        .o_rx_en     (o_rx_en),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_proc_start(o_proc_start),
        .i_proc_done (i_proc_done),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard for buffer writes and start pulses, sampled on the falling edge.
    always @(negedge i_sys_clk) begin
        if (rst_n && o_wr_en) begin
            check("wr_addr", 32'(o_wr_addr), 32'(exp_addr));
            check("wr_data", o_wr_data, exp_data);
            exp_addr = exp_addr + 8'd1;
            wr_count++;
        end
        if (rst_n && o_proc_start) begin
            start_count++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    // One-cycle valid pulse on the selected channels; returns just after the sampling edge.
    task automatic pulse(input bit v1, input bit v2, input logic [31:0] d1, input logic [31:0] d2);
        i_rx1_vld  = v1;
        i_rx2_vld  = v2;
        i_rx1_data = d1;
        i_rx2_data = d2;
        tick();
        i_rx1_vld = 1'b0;
        i_rx2_vld = 1'b0;
    endtask

    task automatic start_capture(input logic [31:0] expect_word);
        int n;
        exp_data    = expect_word;
        exp_addr    = '0;
        wr_count    = 0;
        start_count = 0;
        i_trigger   = 1'b0;
        repeat (4) tick();
        i_trigger = 1'b1;
        n = 0;
        while (!o_busy && n < 10) begin
            tick();
            n++;
        end
        check("trig_busy", 32'(o_busy), 32'd1);
        check("arm_rx_en", 32'(o_rx_en), 32'd1);
        check("arm_err_clr", 32'(o_err), 32'd0);
    endtask

    // Warm-up frames: discarded, so no write may follow them.
    task automatic warm(input bit with_rx2, input int gap, input logic [31:0] d1, input logic [31:0] d2);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, with_rx2, d1, d2);
            check("warm_nowr", 32'(o_wr_en), 32'd0);
            repeat (gap - 1) tick();
        end
    endtask

    task automatic done_pulse();
        i_proc_done = 1'b1;
        tick();
        i_proc_done = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_rx_en", 32'(o_rx_en), 32'd0);
        check("rst_wr_en", 32'(o_wr_en), 32'd0);
        check("rst_addr", 32'(o_wr_addr), 32'd0);
        check("rst_start", 32'(o_proc_start), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Capture 1: aligned mics every 64 cycles
        start_capture(32'hA5A5_5A5A);
        warm(1'b1, 64, 32'hA5A5_0000, 32'h5A5A_0000);
        for (int i = 0; i < 256; i++) begin
            pulse(1'b1, 1'b1, 32'hA5A5_0000, 32'h5A5A_0000);
            check("sim_wr", 32'(o_wr_en), 32'd1);
            if (i < 255) repeat (63) tick();
        end
        tick();
        check("c1_start", 32'(o_proc_start), 32'd1);
        check("c1_rx_off", 32'(o_rx_en), 32'd0);
        tick();
        check("c1_start_end", 32'(o_proc_start), 32'd0);
        check("c1_writes", 32'(wr_count), 32'd256);
        check("c1_starts", 32'(start_count), 32'd1);
        check("c1_busy", 32'(o_busy), 32'd1);
        done_pulse();
        check("c1_idle", 32'(o_busy), 32'd0);
        $display("capture aligned: writes=%0d starts=%0d", wr_count, start_count);

        // Capture 2: mic2 lags mic1 by 10 cycles; warm-up frames carry mic1 only
        start_capture(32'hA5A5_5A5A);
        warm(1'b0, 64, 32'hA5A5_0000, 32'h5A5A_0000);
        for (int i = 0; i < 256; i++) begin
            pulse(1'b1, 1'b0, 32'hA5A5_0000, 32'h5A5A_0000);
            check("lag_nowr", 32'(o_wr_en), 32'd0);
            repeat (9) tick();
            pulse(1'b0, 1'b1, 32'hA5A5_0000, 32'h5A5A_0000);
            check("lag_wr", 32'(o_wr_en), 32'd1);
            if (i < 255) repeat (53) tick();
        end
        repeat (3) tick();
        check("c2_writes", 32'(wr_count), 32'd256);
        check("c2_starts", 32'(start_count), 32'd1);
        check("c2_err", 32'(o_err), 32'd0);
        done_pulse();
        check("c2_idle", 32'(o_busy), 32'd0);
        $display("capture lagged: writes=%0d starts=%0d", wr_count, start_count);

        // Capture 3: mic2 stops after 5 pairs -> skew timeout 64 cycles later
        start_capture(32'h1111_3333);
        warm(1'b0, 16, 32'h1111_2222, 32'h3333_4444);
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444);
            repeat (15) tick();
        end
        pulse(1'b1, 1'b0, 32'h1111_2222, 32'h3333_4444);
        repeat (63) tick();
        check("skew_not_yet", 32'(o_err), 32'd0);
        tick();
        check("skew_err", 32'(o_err), 32'd1);
        check("skew_idle", 32'(o_busy), 32'd0);
        check("skew_rx_off", 32'(o_rx_en), 32'd0);
        check("skew_writes", 32'(wr_count), 32'd5);
        check("skew_nostart", 32'(start_count), 32'd0);
        $display("capture skew: writes=%0d err=%0b", wr_count, o_err);

        // Capture 4: mic1 overrun
        check("err_sticky", 32'(o_err), 32'd1);
        start_capture(32'h2222_4444);
        warm(1'b0, 8, 32'h2222_0000, 32'h4444_0000);
        for (int i = 0; i < 2; i++) begin
            pulse(1'b1, 1'b1, 32'h2222_0000, 32'h4444_0000);
            repeat (7) tick();
        end
        pulse(1'b1, 1'b0, 32'h2222_0000, 32'h4444_0000);
        check("ovr_first_ok", 32'(o_err), 32'd0);
        repeat (4) tick();
        pulse(1'b1, 1'b0, 32'h2222_0000, 32'h4444_0000);
        check("ovr_err", 32'(o_err), 32'd1);
        check("ovr_idle", 32'(o_busy), 32'd0);
        check("ovr_writes", 32'(wr_count), 32'd2);
        check("ovr_nostart", 32'(start_count), 32'd0);
        $display("capture overrun: writes=%0d err=%0b", wr_count, o_err);

        // Capture 5: restart from addr 0, then reset at addr 100
        start_capture(32'h7777_8888);
        warm(1'b0, 8, 32'h7777_0000, 32'h8888_0000);
        for (int i = 0; i < 100; i++) begin
            pulse(1'b1, 1'b1, 32'h7777_0000, 32'h8888_0000);
            repeat (7) tick();
        end
        check("pre_rst_addr", 32'(o_wr_addr), 32'd100);
        check("pre_rst_writes", 32'(wr_count), 32'd100);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_rx_en", 32'(o_rx_en), 32'd0);
        check("mid_rst_wr_en", 32'(o_wr_en), 32'd0);
        check("mid_rst_addr", 32'(o_wr_addr), 32'd0);
        check("mid_rst_data", o_wr_data, 32'd0);
        check("mid_rst_start", 32'(o_proc_start), 32'd0);
        check("mid_rst_err", 32'(o_err), 32'd0);
        i_trigger = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        $display("capture reset: writes before reset=%0d", wr_count);

        // Capture 6: trigger toggled during CAPTURE and PROCESS, done held off
        start_capture(32'h1357_2468);
        warm(1'b1, 8, 32'h1357_FFFF, 32'h2468_0001);
        for (int i = 0; i < 256; i++) begin
            if (i == 50)  i_trigger = 1'b0;
            if (i == 100) i_trigger = 1'b1;
            if (i == 150) i_trigger = 1'b0;
            if (i == 200) i_trigger = 1'b1;
            pulse(1'b1, 1'b1, 32'h1357_FFFF, 32'h2468_0001);
            repeat (7) tick();
        end
        i_trigger = 1'b0;
        repeat (5) tick();
        i_trigger = 1'b1;
        repeat (45) tick();
        check("proc_busy", 32'(o_busy), 32'd1);
        check("proc_rx_off", 32'(o_rx_en), 32'd0);
        check("proc_starts", 32'(start_count), 32'd1);
        check("proc_writes", 32'(wr_count), 32'd256);
        done_pulse();
        check("proc_idle", 32'(o_busy), 32'd0);
        done_pulse();
        repeat (5) tick();
        check("idle_done_ign", 32'(o_busy), 32'd0);
        check("idle_starts", 32'(start_count), 32'd1);
        $display("capture toggled: writes=%0d starts=%0d", wr_count, start_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
